// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ      = 4;
  localparam int IDX_W        = 2;
  localparam int HOLD_MAX_DEF = 255;

endpackage

// File: rtl/decoder2_4.sv
// 2-to-4 one-hot decoder.
module decoder2_4 (
  input  logic [1:0] i,
  output logic [3:0] o
);

  always_comb begin
    o = 4'b0000;
    unique case (i)
      2'd0: o = 4'b0001;
      2'd1: o = 4'b0010;
      2'd2: o = 4'b0100;
      2'd3: o = 4'b1000;
      default: o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter, registered grant, no preemption.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX busy cycles.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  if (2**CNT_W <= HOLD_MAX) begin : g_bad_cfg
    $error("rr_arbiter4: CNT_W too narrow for HOLD_MAX");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       dec_raw;
  logic             hold_exp;

  // First set bit at ptr+1 .. ptr+4; later offsets are overwritten by earlier.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic [IDX_W-1:0] k;
    rr_pick = p;
    for (int s = NUM_REQ; s >= 1; s--) begin
      k = p + IDX_W'(s);
      if (r[k]) rr_pick = k;
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q;

  assign hold_exp = (state_q == ST_BUSY) && req[idx_q]
                 && (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign cnt_d    = (state_q == ST_BUSY) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= hold_exp;
    end
  end

  assign timeout = tmo_q;
`else
  assign hold_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req[idx_q] || hold_exp) begin
          ptr_d   = idx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  decoder2_4 u_dec (
    .i (idx_q),
    .o (dec_raw)
  );

  assign grant_valid = (state_q == ST_BUSY);
  assign grant_idx   = idx_q;
  assign grant       = dec_raw & {NUM_REQ{grant_valid}};

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(
    .HOLD_MAX (4),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // got/exp packed as {timeout, valid, idx, grant}
  task automatic chk(
    input string      tag,
    input logic [3:0] g,
    input logic [1:0] idx,
    input logic       v,
    input logic       t
  );
    logic [7:0] got;
    logic [7:0] exp;
    got = {timeout, grant_valid, grant_idx, grant};
    exp = {t, v, idx, g};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got t/v/idx/g=%b want %b", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    logic [4:0] got;
    got = {timeout, grant_valid, grant};
    checks++;
    assert (got === 5'b0) else begin
      errors++;
      $error("FAIL %s: got t/v/g=%b want 00000", tag, got);
    end
  endtask

  initial begin
    reset_p = 1'b1;
    req     = 4'b1111;
    tick(2);
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset_p = 1'b0;

    tick();
    chk("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1110;
    tick();
    chk_idle("gap0");
    tick();
    chk("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1100;
    tick();
    chk_idle("gap1");
    tick();
    chk("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1000;
    tick();
    chk_idle("gap2");
    tick();
    chk("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0111;
    tick();
    chk_idle("gap3");
    tick();
    chk("rot_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    req = 4'b0000;
    tick();
    chk_idle("rel_all");
    req = 4'b0100;
    tick();
    chk("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(3);
    chk("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_idle("single_drop");

    req = 4'b0010;
    tick();
    chk("np_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("np_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b1000;
    tick();
    chk_idle("np_gap");
    tick();
    chk("np_c3", 4'b1000, 2'd3, 1'b1, 1'b0);

    req = 4'b1001;
    #2;
    reset_p = 1'b1;
    #1;
    chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    reset_p = 1'b0;
    tick();
    chk("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    req = 4'b0000;
    tick();
    chk_idle("idle_rel");
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_idle("idle_run");
    end
    req = 4'b1111;
    tick();
    chk("after_idle", 4'b0010, 2'd1, 1'b1, 1'b0);

    req = 4'b0000;
    tick();
    chk_idle("pre_tmo");
    req = 4'b0011;
    tick();
    chk("tmo_c0", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    tick(3);
    chk("tmo_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick();
    chk("tmo_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk("tmo_next", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      chk("no_tmo", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (bus, FND driver, UART TX) between four clients.
- Holds a registered 2-bit grant index and expands it to a one-hot grant vector through the team's 2-to-4 decoder.
- Sits between the requesting blocks and the shared resource's mux select.

Parameters:
- HOLD_MAX, 255, maximum cycles one grant may be held before forced release (used only with the optional feature).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge.
- reset_p  input  1  asynchronous, active-high reset.
- req  input  4  request per client; a client holds its bit high for as long as it needs the resource.
- grant  output  4  one-hot grant; all zero when no grant is active.
- grant_idx  output  2  encoded index of the granted client; valid only while grant_valid=1.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when the optional feature is absent.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high on reset_p.
- Reset values: state=IDLE, grant=4'b0000, grant_idx=2'd0, grant_valid=0, timeout=0, ptr=2'd3, hold counter=0.
  - ptr is the last-served index. Resetting it to 3 makes client 0 highest priority first.
- FSM has two states, IDLE and BUSY.
- IDLE, when req != 0 at a rising edge:
  - Select the first set bit searching ptr+1, ptr+2, ptr+3, ptr+4 (all mod 4).
  - Register that index into grant_idx, set grant_valid=1, go to BUSY.
  - grant is visible one cycle after req is sampled (registered, latency 1).
- IDLE, when req == 0: stay in IDLE, outputs unchanged at zero.
- BUSY:
  - grant = decoder output of grant_idx, gated by grant_valid.
  - While req[grant_idx]=1: stay in BUSY. Other requests are ignored; there is no preemption.
- BUSY, when req[grant_idx]=0 at an edge:
  - grant_valid=0, grant=0, ptr=grant_idx, go to IDLE.
  - Exactly one idle cycle separates consecutive grants. The next arbitration happens on the following edge.
- A requester that drops and re-raises req during another client's grant is simply pending. No state is kept per requester beyond req.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). After reset release, arbitration restarts from client 0.
- grant is always one-hot or zero. grant_idx never changes while BUSY.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter equals HOLD_MAX-1 and req[grant_idx] is still 1, the next edge forces release exactly like a normal release: ptr=grant_idx, go to IDLE, timeout=1 for one cycle.
  - The starved requester competes again under normal rotation, so it is served last among those pending.
  - A natural release on the same edge takes priority; timeout stays 0.
- Undefined: no counter is built, timeout is constant 0, and a grant is held indefinitely.

Decomposition:
- Package/header rr_arb_pkg:
  - State encodings ST_IDLE=1'b0 and ST_BUSY=1'b1.
  - NUM_REQ=4.
  - Default HOLD_MAX.
- Sub-module decoder2_4, instantiated once:
  - i <= grant_idx, o => raw one-hot.
  - grant = raw one-hot AND {4{grant_valid}}.
- Rotating priority search stays inline as a combinational function.

Test Plan:
- Reset with req=4'b1111 held: first grant=4'b0001, then drop req[0] → after the idle cycle grant=4'b0010, then 4'b0100, then 4'b1000, then 4'b0001 again.
- Single requester: req=4'b0100 at cycle 5 → grant=4'b0100, grant_idx=2 at cycle 6. Drop at cycle 10 → grant=0 at cycle 11.
- No preemption: client 1 granted, then req[3] raised → grant stays 4'b0010 until req[1] drops, then grant=4'b1000 after one idle cycle.
- Reset mid-grant: assert reset_p asynchronously while grant=4'b1000 → grant, grant_valid and grant_idx go to 0 before the next edge. With req=4'b1001 after release → grant=4'b0001.
- ARB_TIMEOUT_EN with HOLD_MAX=4 and req=4'b0011 held: client 0 forced off after 4 BUSY cycles with a timeout pulse, client 1 granted next. Without the macro, client 0 holds for 100+ cycles and timeout stays 0.
- Idle input: req=0 for 50 cycles → grant_valid=0 throughout and ptr unchanged; the next req=4'b1111 grants the client after the last-served one.
